// File: rtl/digit_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan_pkg
// Brief    : Shared states, sizes and nibble selection for the digit scanner.
// Revision : 1.0
// ============================================================================
package digit_scan_pkg;

    localparam int NDIG  = 4;
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    function automatic logic [NIB_W-1:0] pick_nibble(
        input logic [NDIG*NIB_W-1:0] d,
        input logic [1:0]            i
    );
        logic [NIB_W-1:0] w_nib;
        case (i)
            2'd0:    w_nib = d[3:0];
            2'd1:    w_nib = d[7:4];
            2'd2:    w_nib = d[11:8];
            default: w_nib = d[15:12];
        endcase
        return w_nib;
    endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Brief    : Loadable down-counter shared by the ON and GAP phases; tc at zero.
// Revision : 1.0
// ============================================================================
module scan_timer
    import digit_scan_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/digit_scan.sv
`default_nettype none
// ============================================================================
// Module   : digit_scan
// Brief    : Four-digit display scan controller with blanking gaps and
//            frame-synchronous data update. DIGIT_SCAN_LZB_EN adds
//            leading-zero blanking.
// Revision : 1.0
// ============================================================================
module digit_scan
    import digit_scan_pkg::*;
#(
    parameter int DIV = 50000,
    parameter int GAP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  load,
    input  logic [NDIG*NIB_W-1:0] data_in,
    input  logic [NDIG-1:0]       digit_en,
    output logic [1:0]            sel,
    output logic                  ena,
    output logic [NIB_W-1:0]      nibble,
    output logic                  frame
);

    localparam int c_cnt_max = (DIV > GAP) ? DIV : GAP;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_div_m1 = c_cnt_w'(DIV - 1);
    localparam logic [c_cnt_w-1:0] c_gap_m1 = c_cnt_w'(GAP - 1);

    state_t                  r_state, w_state_nx;
    logic [1:0]              r_sel, w_sel_nx;
    logic                    r_ena, w_ena_nx;
    logic [NIB_W-1:0]        r_nibble;
    logic [NDIG*NIB_W-1:0]   r_active, w_active_nx;
    logic [NDIG*NIB_W-1:0]   r_shadow, w_shadow_nx;
    logic                    r_pending, w_pending_nx;
    logic                    w_wrap;
    logic                    w_tc, w_tmr_clr, w_tmr_load;
    logic [c_cnt_w-1:0]      w_tmr_val;
    logic [NDIG-1:0]         w_blank;

    scan_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_tmr_clr),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .tc       (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_ena     <= 1'b0;
            r_nibble  <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sel     <= w_sel_nx;
            r_ena     <= w_ena_nx;
            r_nibble  <= pick_nibble(w_active_nx, w_sel_nx);
            r_active  <= w_active_nx;
            r_shadow  <= w_shadow_nx;
            r_pending <= w_pending_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_tmr_clr  = 1'b0;
        w_tmr_load = 1'b0;
        w_tmr_val  = c_div_m1;
        w_wrap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nx = S_ON;
                w_tmr_load = 1'b1;
            end
            S_ON: begin
                if (w_tc) begin
                    w_state_nx = S_GAP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = c_gap_m1;
                end
            end
            S_GAP: begin
                if (w_tc) begin
                    w_state_nx = S_ON;
                    w_tmr_load = 1'b1;
                    w_sel_nx   = r_sel + 2'd1;
                    w_wrap     = (r_sel == 2'd3);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        // Dropping run abandons the slot outright, whatever state we are in.
        if (!run) begin
            w_state_nx = S_IDLE;
            w_sel_nx   = '0;
            w_tmr_clr  = 1'b1;
            w_tmr_load = 1'b0;
            w_wrap     = 1'b0;
        end
    end

    // Shadow/active double buffer; a load on the wrap cycle bypasses the shadow.
    always_comb begin
        w_shadow_nx  = load ? data_in : r_shadow;
        w_pending_nx = r_pending | load;
        w_active_nx  = r_active;
        if (w_wrap) begin
            w_pending_nx = 1'b0;
            if (load) begin
                w_active_nx = data_in;
            end else if (r_pending) begin
                w_active_nx = r_shadow;
            end
        end
    end

`ifdef DIGIT_SCAN_LZB_EN
    always_comb begin
        w_blank    = '0;
        w_blank[3] = (w_active_nx[15:12] == '0);
        w_blank[2] = w_blank[3] & (w_active_nx[11:8] == '0);
        w_blank[1] = w_blank[2] & (w_active_nx[7:4] == '0);
    end
`else
    assign w_blank = '0;
`endif

    assign w_ena_nx = (w_state_nx == S_ON) & digit_en[w_sel_nx] & ~w_blank[w_sel_nx];

    assign sel    = r_sel;
    assign ena    = r_ena;
    assign nibble = r_nibble;
    assign frame  = w_wrap;

endmodule
`default_nettype wire
